hpdcache_rsp_router: RTL
========================

Name: hpdcache_rsp_router

Overview:
- Return-path companion to the cache's fixed-priority request arbiter.
- Records, in order, which requester was granted each accepted request.
- Steers each in-order response from the shared downstream port back to that requester, with per-requester valid/ready handshake.
- Applies back-pressure to the request side when the outstanding-transaction tracker is full.

Parameters:
- N, default 4: number of requesters; must be >= 1.
- DEPTH, default 4: maximum number of outstanding transactions; must be >= 2.
- W, default 32: response payload width in bits.

Ports:
- clk_i  input  1  clock (already decided).
- rst_ni  input  1  reset, asynchronous, active-low (already decided).
- req_gnt_i  input  N  one-hot grant vector of the request currently presented downstream.
- req_fire_i  input  1  request accepted downstream this cycle; push req_gnt_i.
- req_ready_o  output  1  tracker can accept a new request; ANDed into arbiter ready by the parent.
- rsp_valid_i  input  1  downstream response valid.
- rsp_ready_o  output  1  response consumed by the selected requester.
- rsp_data_i  input  W  response payload.
- rsp_valid_o  input/output: output  N  per-requester response valid; at most one bit set.
- rsp_ready_i  input  N  per-requester response ready.
- rsp_data_o  output  W  response payload, broadcast to all requesters.
- outstanding_o  output  $clog2(DEPTH+1)  number of tracked, unanswered requests.
- unexpected_rsp_o  output  1  single-cycle pulse: response arrived with no outstanding request.

Behaviour:
- Storage: circular FIFO of DEPTH entries, each N bits wide.
  - wptr and rptr are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0; DEPTH need not be a power of two.
  - count is $clog2(DEPTH+1) bits.
- Reset (async assertion, sync deassertion handled by parent):
  - wptr = rptr = 0, count = 0, unexpected_rsp_o = 0, all entries cleared to 0.
  - Resulting outputs: req_ready_o = 1, rsp_valid_o = 0, rsp_ready_o = 0, outstanding_o = 0.
- empty = (count == 0); full = (count == DEPTH).
- req_ready_o = !full. Combinational from registers only; no pop-to-push bypass, so no path from rsp_ready_i to req_ready_o.
- push = req_fire_i & !full.
  - Writes req_gnt_i at wptr and increments wptr.
  - req_fire_i while full is a protocol violation: ignored and asserted against.
- Routing is combinational, zero added latency:
  - head = entry[rptr].
  - rsp_valid_o = head & {N{rsp_valid_i & !empty}}.
  - rsp_ready_o = !empty & |(head & rsp_ready_i).
  - rsp_data_o = rsp_data_i, unconditionally.
- pop = rsp_valid_i & rsp_ready_o. Increments rptr.
- count update: next = count + push - pop.
  - Simultaneous push and pop leaves count unchanged and advances both pointers.
  - Push and pop in the same cycle is legal at any fill level except: full blocks the push; empty cannot pop.
- Empty with rsp_valid_i = 1:
  - rsp_ready_o = 0, rsp_valid_o = 0; the response is not consumed.
  - unexpected_rsp_o = 1 in the following cycle, for one cycle per offending cycle (registered).
- No same-cycle bypass: a request pushed in cycle t is routable from cycle t+1. Downstream minimum request-to-response latency is 1 cycle.
- Back-pressure: while the selected requester holds rsp_ready_i = 0, head is unchanged and rsp_valid_o stays asserted to the same requester.
- outstanding_o = count (registered).
- Reset mid-operation discards all tracked entries immediately; in-flight responses after reset raise unexpected_rsp_o.
- Assertions (simulation only):
  - $onehot(req_gnt_i) when push.
  - !(req_fire_i & full).
  - $onehot0(rsp_valid_o).
  - count <= DEPTH.

Test Plan:
- Reset, then idle → req_ready_o = 1, outstanding_o = 0, rsp_valid_o = 0000, unexpected_rsp_o = 0.
- Push grants 0010, 1000, 0001 on consecutive cycles; return 3 responses (data 0xA, 0xB, 0xC), all rsp_ready_i = 1111 → rsp_valid_o = 0010, 1000, 0001 in order; rsp_data_o matches; outstanding_o goes 3 → 0.
- Push 4 entries (DEPTH = 4) → req_ready_o = 0, outstanding_o = 4. Assert req_fire_i → no state change, assertion fires. One pop → req_ready_o = 1 next cycle.
- Head 0100 with rsp_ready_i = 1011 for 3 cycles → rsp_valid_o = 0100 held, rsp_ready_o = 0. rsp_ready_i[2] = 1 → pop; next head presented.
- count = 2, simultaneous push (0001) and pop for 6 cycles → count stays 2; pointers wrap; order preserved across wrap.
- rsp_valid_i = 1 while empty → rsp_ready_o = 0; unexpected_rsp_o = 1 exactly one cycle later. Assert rst_ni low with count = 3 → outstanding_o = 0 immediately.

Source files
------------

// File: rtl/hpdcache_rsp_router.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hpdcache_rsp_router                                             |
// | Purpose  : Return-path companion to the fixed-priority request arbiter.    |
// |            Records the one-hot grant of every accepted request in a        |
// |            circular FIFO and steers each in-order downstream response      |
// |            back to the requester that issued it.                           |
// | Ports    : clk_i, rst_ni (async, active-low)                               |
// |            req_gnt_i/req_fire_i/req_ready_o  : request-side tracking       |
// |            rsp_valid_i/rsp_ready_o/rsp_data_i: shared downstream response  |
// |            rsp_valid_o/rsp_ready_i/rsp_data_o: per-requester response      |
// |            outstanding_o    : number of tracked, unanswered requests       |
// |            unexpected_rsp_o : pulse, response seen with nothing tracked    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module hpdcache_rsp_router #(
   parameter int unsigned N     = 4,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 32
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [N-1:0]                 req_gnt_i,
   input  logic                         req_fire_i,
   output logic                         req_ready_o,
   input  logic                         rsp_valid_i,
   output logic                         rsp_ready_o,
   input  logic [W-1:0]                 rsp_data_i,
   output logic [N-1:0]                 rsp_valid_o,
   input  logic [N-1:0]                 rsp_ready_i,
   output logic [W-1:0]                 rsp_data_o,
   output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
   output logic                         unexpected_rsp_o
);

   localparam int unsigned c_ptr_w = $clog2(DEPTH);
   localparam int unsigned c_cnt_w = $clog2(DEPTH+1);
   localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH-1);
   localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);

   logic [N-1:0]       r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wptr;
   logic [c_ptr_w-1:0] r_rptr;
   logic [c_cnt_w-1:0] r_count;
   logic               r_unexpected;

   logic               w_empty;
   logic               w_full;
   logic               w_push;
   logic               w_pop;
   logic [N-1:0]       w_head;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == c_depth);

   // Ready depends on registered state only: a pop in the same cycle does
   // not free a slot, which keeps rsp_ready_i off the request-side path.
   assign req_ready_o = !w_full;
   assign w_push      = req_fire_i & !w_full;

   // Zero-latency routing of the response to the requester at the head.
   assign w_head      = r_mem[r_rptr];
   assign rsp_valid_o = w_head & {N{rsp_valid_i & !w_empty}};
   assign rsp_ready_o = !w_empty & (|(w_head & rsp_ready_i));
   assign rsp_data_o  = rsp_data_i;
   assign w_pop       = rsp_valid_i & rsp_ready_o;

   assign outstanding_o    = r_count;
   assign unexpected_rsp_o = r_unexpected;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
         r_unexpected <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= req_gnt_i;
            // Explicit wrap so that non-power-of-two depths work.
            r_wptr <= (r_wptr == c_last_ptr) ? '0 : r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == c_last_ptr) ? '0 : r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         r_unexpected <= rsp_valid_i & w_empty;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (rst_ni) begin
         if (w_push) begin
            assert ($onehot(req_gnt_i))
               else $error("grant vector not one-hot on push");
         end
         assert (!(req_fire_i && w_full))
            else $error("request fired while tracker full");
         assert ($onehot0(rsp_valid_o))
            else $error("more than one response valid asserted");
         assert (r_count <= c_depth)
            else $error("outstanding count exceeds depth");
      end
   end
`endif

endmodule
`default_nettype wire
